// File: rtl/sampa_pon_seq.sv
// sampa_pon_seq: staged power-on/power-off sequencer for N_SAMPA SAMPA chips with a timed hard reset.
// Optional power-good supervision is compiled in when SAMPA_PON_PGOOD_CHECK_EN is defined.
module sampa_pon_seq #(
   parameter int N_SAMPA = 4,
   parameter int CNT_W   = 24
) (
   input  logic               ACLK,
   input  logic               ARESET,
   input  logic               cmd_on,
   input  logic               cmd_off,
   input  logic [CNT_W-1:0]   on_delay,
   input  logic [CNT_W-1:0]   rst_width,
   input  logic [N_SAMPA-1:0] pgood,
   output logic [N_SAMPA-1:0] pwr_en,
   output logic               sampa_rst,
   output logic               busy,
   output logic               ready,
   output logic               fault,
   output logic [2:0]         state
);

   localparam int IDX_W = (N_SAMPA > 1) ? $clog2(N_SAMPA) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPA - 1);

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PWR_UP   = 3'd1;
   localparam logic [2:0] ST_RST_HOLD = 3'd2;
   localparam logic [2:0] ST_READY    = 3'd3;
   localparam logic [2:0] ST_PWR_DN   = 3'd4;
   localparam logic [2:0] ST_FAULT    = 3'd5;

   logic [2:0]         state_q;
   logic [N_SAMPA-1:0] pwr_en_q;
   logic               rst_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   idx_q;

   logic [CNT_W-1:0]   on_load;
   logic [CNT_W-1:0]   rst_load;
   logic               step_done;
   logic               step_bad;
   logic               ready_bad;
   logic [N_SAMPA-1:0] idx_bit;
   logic [N_SAMPA-1:0] next_bit;

   // A programmed delay of zero still costs one cycle so the counter never underflows.
   assign on_load   = (on_delay  == '0) ? CNT_W'(1) : on_delay;
   assign rst_load  = (rst_width == '0) ? CNT_W'(1) : rst_width;
   assign step_done = (cnt_q == CNT_W'(1));

   always_comb begin
      idx_bit  = '0;
      next_bit = '0;
      idx_bit[idx_q] = 1'b1;
      if (idx_q != LAST_IDX) next_bit[idx_q + 1'b1] = 1'b1;
   end

`ifdef SAMPA_PON_PGOOD_CHECK_EN
   assign step_bad  = ~pgood[idx_q];
   assign ready_bad = |(pwr_en_q & ~pgood);
`else
   logic unused_pgood;
   assign unused_pgood = ^pgood;
   assign step_bad     = 1'b0;
   assign ready_bad    = 1'b0;
`endif

   // cmd_on/cmd_off are single-cycle pulses acted on at the edge that samples them;
   // cmd_off wins when both are high, and ignored commands leave no pending state.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q  <= ST_IDLE;
         pwr_en_q <= '0;
         rst_q    <= 1'b0;
         cnt_q    <= '0;
         idx_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_on && !cmd_off) begin
                  state_q  <= ST_PWR_UP;
                  idx_q    <= '0;
                  cnt_q    <= on_load;
                  pwr_en_q <= N_SAMPA'(1);
                  rst_q    <= 1'b1;
               end
            end
            ST_PWR_UP: begin
               if (cmd_off) begin
                  state_q <= ST_PWR_DN;
                  cnt_q   <= on_load;
               end else if (step_done) begin
                  if (step_bad) begin
                     state_q  <= ST_FAULT;
                     pwr_en_q <= '0;
                     cnt_q    <= '0;
                  end else if (idx_q == LAST_IDX) begin
                     state_q <= ST_RST_HOLD;
                     cnt_q   <= rst_load;
                  end else begin
                     idx_q    <= idx_q + 1'b1;
                     pwr_en_q <= pwr_en_q | next_bit;
                     cnt_q    <= on_load;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_RST_HOLD: begin
               if (cmd_off) begin
                  state_q <= ST_PWR_DN;
                  cnt_q   <= on_load;
               end else if (step_done) begin
                  state_q <= ST_READY;
                  rst_q   <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_READY: begin
               if (cmd_off) begin
                  state_q <= ST_PWR_DN;
                  rst_q   <= 1'b1;
                  cnt_q   <= on_load;
               end else if (ready_bad) begin
                  state_q  <= ST_FAULT;
                  pwr_en_q <= '0;
                  rst_q    <= 1'b1;
               end
            end
            ST_PWR_DN: begin
               // idx_q already points at the highest enabled chip on entry.
               if (step_done) begin
                  pwr_en_q <= pwr_en_q & ~idx_bit;
                  if (idx_q == '0) begin
                     state_q <= ST_IDLE;
                     rst_q   <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     idx_q <= idx_q - 1'b1;
                     cnt_q <= on_load;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_FAULT: begin
               if (cmd_off) begin
                  state_q <= ST_IDLE;
                  rst_q   <= 1'b0;
                  idx_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               pwr_en_q <= '0;
               rst_q    <= 1'b0;
               cnt_q    <= '0;
               idx_q    <= '0;
            end
         endcase
      end
   end

   assign state     = state_q;
   assign pwr_en    = pwr_en_q;
   assign sampa_rst = rst_q;
   assign busy      = (state_q == ST_PWR_UP) || (state_q == ST_RST_HOLD) || (state_q == ST_PWR_DN);
   assign ready     = (state_q == ST_READY);
   assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_sampa_pon_seq.sv
// tb_sampa_pon_seq: directed and randomized stimulus for sampa_pon_seq, checked every cycle
// against a timeline model that derives the expected outputs from elapsed cycles since each command.
module tb_sampa_pon_seq;

   localparam int N  = 4;
   localparam int CW = 24;

   localparam int M_IDLE = 0;
   localparam int M_UP   = 1;
   localparam int M_DN   = 2;
   localparam int M_FLT  = 3;

   logic          aclk = 1'b0;
   logic          areset;
   logic          cmd_on;
   logic          cmd_off;
   logic [CW-1:0] on_delay;
   logic [CW-1:0] rst_width;
   logic [N-1:0]  pgood;
   logic [N-1:0]  pwr_en;
   logic          sampa_rst;
   logic          busy;
   logic          ready;
   logic          fault;
   logic [2:0]    state;

   int cyc;
   int checks_total;
   int checks_passed;
   int mode;
   int on_t;
   int off_t;
   int k_off;
   int d_eff;
   int r_eff;
   int n_up;

   sampa_pon_seq #(.N_SAMPA(N), .CNT_W(CW)) dut (
      .ACLK      (aclk),
      .ARESET    (areset),
      .cmd_on    (cmd_on),
      .cmd_off   (cmd_off),
      .on_delay  (on_delay),
      .rst_width (rst_width),
      .pgood     (pgood),
      .pwr_en    (pwr_en),
      .sampa_rst (sampa_rst),
      .busy      (busy),
      .ready     (ready),
      .fault     (fault),
      .state     (state)
   );

   // clock / reset
   always #5 aclk = ~aclk;

   // ---------------- reference model ----------------
   function automatic int exp_state();
      int t;
      case (mode)
         M_UP: begin
            t = cyc - on_t + 1;
            if (t < 1 + N * d_eff)              return 1;
            else if (t < 1 + N * d_eff + r_eff) return 2;
            else                                return 3;
         end
         M_DN:    return 4;
         M_FLT:   return 5;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_count();
      int t;
      case (mode)
         M_UP: begin
            t = cyc - on_t + 1;
            if (t < 1 + N * d_eff) return 1 + (t - 1) / d_eff;
            else                   return N;
         end
         M_DN:    return k_off - (cyc - off_t) / d_eff;
         default: return 0;
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
   endtask

   task automatic check_all();
      int s;
      logic [31:0] m;
      s = exp_state();
      m = (32'd1 << exp_count()) - 32'd1;
      check("state",     32'(state),     32'(s));
      check("pwr_en",    32'(pwr_en),    m);
      check("sampa_rst", 32'(sampa_rst), 32'(s == 1 || s == 2 || s == 4 || s == 5));
      check("busy",      32'(busy),      32'(s == 1 || s == 2 || s == 4));
      check("ready",     32'(ready),     32'(s == 3));
      check("fault",     32'(fault),     32'(s == 5));
   endtask

   // ---------------- drivers ----------------
   task automatic set_delays(input int d, input int r);
      on_delay  = CW'(d);
      rst_width = CW'(r);
      d_eff     = (d == 0) ? 1 : d;
      r_eff     = (r == 0) ? 1 : r;
   endtask

   task automatic step(input bit on, input bit off);
      int pre_s;
      int pre_k;
      pre_s   = exp_state();
      pre_k   = exp_count();
      cmd_on  = on;
      cmd_off = off;
      @(posedge aclk);
      #1;
      cyc++;
      cmd_on  = 1'b0;
      cmd_off = 1'b0;
      if (pre_s == 0 && on && !off) begin
         mode = M_UP;
         on_t = cyc;
      end else if (off && (pre_s == 1 || pre_s == 2 || pre_s == 3)) begin
         mode  = M_DN;
         off_t = cyc;
         k_off = pre_k;
      end else if (off && pre_s == 5) begin
         mode = M_IDLE;
      end
      if (mode == M_DN && (cyc - off_t) / d_eff >= k_off) mode = M_IDLE;
      check_all();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      @(posedge aclk);
      #1;
      cyc++;
      areset = 1'b0;
      mode   = M_IDLE;
      check_all();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      areset        = 1'b1;
      cmd_on        = 1'b0;
      cmd_off       = 1'b0;
      pgood         = '1;
      cyc           = 0;
      checks_total  = 0;
      checks_passed = 0;
      mode          = M_IDLE;
      on_t          = 0;
      off_t         = 0;
      k_off         = 0;
      set_delays(0, 0);
      do_reset();
      do_reset();

      // nominal power-up, then power-down from READY
      set_delays(10, 5);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (28) step(1'b0, 1'b0);
      check("ready_at_46", 32'(ready), 32'd1);
      step(1'b0, 1'b1);
      repeat (45) step(1'b0, 1'b0);

      // abort during the first power step
      step(1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (12) step(1'b0, 1'b0);

      // zero delays, then simultaneous on/off in READY
      set_delays(0, 0);
      step(1'b1, 1'b0);
      repeat (N + 3) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      repeat (N + 2) step(1'b0, 1'b0);

      // reset mid-sequence with two chips enabled
      set_delays(3, 2);
      step(1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      check("pwr_en_before_reset", 32'(pwr_en), 32'h3);
      do_reset();
      step(1'b0, 1'b0);

      // randomized sequences
      for (int it = 0; it < 12; it++) begin
         set_delays(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
         if ($urandom_range(0, 1) == 1) step(1'($urandom_range(0, 1)), 1'b1);
         step(1'b1, 1'b0);
         n_up = int'($urandom_range(0, N * d_eff + r_eff + 4));
         for (int c = 0; c < n_up; c++) step($urandom_range(0, 3) == 0, 1'b0);
         step(1'($urandom_range(0, 1)), 1'b1);
         for (int c = 0; c < 60 && mode != M_IDLE; c++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         check("seq_end_state", 32'(state), 32'd0);
      end

`ifdef SAMPA_PON_PGOOD_CHECK_EN
      // chip 2 loses power-good: fault at its step expiry, cleared only by cmd_off
      set_delays(3, 2);
      pgood = 4'b1011;
      step(1'b1, 1'b0);
      repeat (8) step(1'b0, 1'b0);
      @(posedge aclk);
      #1;
      cyc++;
      mode = M_FLT;
      check_all();
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      pgood = '1;
      step(1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/sampa_pon_seq.md
SAMPA_PON_SEQ -- requirements
Module: sampa_pon_seq

Interface
REQ-001 SHALL have parameter N_SAMPA, default 4: number of SAMPA chips sequenced (1..8).
REQ-002 SHALL have parameter CNT_W, default 24: width of the delay counters.
REQ-003 SHALL have port ACLK  in  1: the single clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port ARESET  in  1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_on  in  1: single-cycle request to start power-up, from the AXI register bank.
REQ-006 SHALL have port cmd_off  in  1: single-cycle request to start power-down.
REQ-007 SHALL have port on_delay  in  CNT_W: cycles to wait after each chip power step.
REQ-008 SHALL have port rst_width  in  CNT_W: number of cycles sampa_rst is held asserted.
REQ-009 SHALL have port pgood  in  N_SAMPA: per-chip power-good inputs, already synchronised.
REQ-010 SHALL have port pwr_en  out  N_SAMPA: per-chip regulator enables.
REQ-011 SHALL have port sampa_rst  out  1: SAMPA hard reset, active-high.
REQ-012 SHALL have port busy  out  1: high in every state except IDLE, READY and FAULT.
REQ-013 SHALL have port ready  out  1: high only in READY.
REQ-014 SHALL have port fault  out  1: high only in FAULT.
REQ-015 SHALL have port state  out  3: encoded FSM state for status readback.

Function
REQ-016 SHALL use states IDLE=0, PWR_UP=1, RST_HOLD=2, READY=3, PWR_DN=4, FAULT=5.
REQ-017 SHALL, on cmd_on in IDLE, set pwr_en[0] and enter PWR_UP on the next edge, with chip index 0 and the counter loaded with on_delay.
REQ-018 SHALL, in PWR_UP, decrement the counter each cycle; at count==1 it SHALL set pwr_en[idx+1] and reload the counter, or, when idx==N_SAMPA-1, enter RST_HOLD.
REQ-019 SHALL treat an on_delay or rst_width value of 0 as 1, so every step lasts at least one cycle.
REQ-020 SHALL sample on_delay and rst_width only at counter load; mid-step changes SHALL take effect at the next load.
REQ-021 SHALL hold sampa_rst=1 from PWR_UP entry through RST_HOLD, then clear it and enter READY after rst_width cycles in RST_HOLD.
REQ-022 SHALL, on cmd_off in PWR_UP, RST_HOLD or READY, enter PWR_DN next cycle with sampa_rst=1 and idx=highest enabled chip.
REQ-023 SHALL, in PWR_DN, clear pwr_en[idx] at each on_delay expiry in descending order, and enter IDLE with sampa_rst=0 after pwr_en[0] clears.
REQ-024 SHALL ignore cmd_on in every state other than IDLE, and ignore cmd_off in IDLE and PWR_DN.
REQ-025 SHALL give cmd_off priority when cmd_on and cmd_off are both high in the same cycle; in IDLE both are then ignored.
REQ-026 SHALL leave FAULT only through cmd_off, which SHALL enter IDLE directly because all enables are already off.

Reset
REQ-027 SHALL, while ARESET=1, force state=IDLE, pwr_en=0, sampa_rst=0, busy=0, ready=0, fault=0, counter=0 and idx=0.
REQ-028 SHALL, when reset arrives mid-sequence, drop all enables on the same edge; no reverse-order power-down SHALL be attempted.

Configuration
REQ-029 SHALL, with macro SAMPA_PON_PGOOD_CHECK_EN defined, check pgood[idx] at each PWR_UP step expiry and continuously in READY.
REQ-030 SHALL, in that build, enter FAULT on any low pgood of an enabled chip, clearing all pwr_en and holding sampa_rst=1.
REQ-031 SHALL, with the macro undefined, leave pgood unconnected internally so that FAULT is unreachable and fault stays 0.

Verification
REQ-032 SHALL cover: N_SAMPA=4, on_delay=10, rst_width=5, cmd_on pulse -> pwr_en steps 1,3,7,F at cycles +1,+11,+21,+31; ready at +46.
REQ-033 SHALL cover: cmd_off in READY -> pwr_en F,7,3,1,0 at 10-cycle spacing, sampa_rst=1 throughout, then state=IDLE.
REQ-034 SHALL cover: cmd_off asserted 3 cycles after cmd_on -> PWR_DN, pwr_en 1->0 after 10 cycles, then IDLE.
REQ-035 SHALL cover: on_delay=0 -> one chip enabled per cycle; cmd_on and cmd_off together in READY -> PWR_DN.
REQ-036 SHALL cover: ARESET pulse while pwr_en=3 -> next edge pwr_en=0, state=IDLE, all flags 0.
REQ-037 SHALL cover: with SAMPA_PON_PGOOD_CHECK_EN defined, pgood[2] low at step 2 -> fault=1, pwr_en=0; then cmd_off -> IDLE.
